// File: rtl/stats_pkg.sv
// Shared definitions for the statistics AXI4-Lite reader.
//   - word indices of the register map (byte offset >> 2)
//   - CTRL bit positions
//   - AXI response codes
//   - default block identifier
//   - FSM state types for the write and read channels
package stats_pkg;

    // Register word indices, decoded from address bits [4:2]
    localparam logic [2:0] REG_PKT_LO   = 3'd0;  // 0x00
    localparam logic [2:0] REG_PKT_HI   = 3'd1;  // 0x04
    localparam logic [2:0] REG_BYTE_LO  = 3'd2;  // 0x08
    localparam logic [2:0] REG_BYTE_HI  = 3'd3;  // 0x0C
    localparam logic [2:0] REG_CTRL     = 3'd4;  // 0x10
    localparam logic [2:0] REG_SNAP_CNT = 3'd5;  // 0x14
    localparam logic [2:0] REG_ID       = 3'd6;  // 0x18
    localparam logic [2:0] REG_UNMAPPED = 3'd7;  // 0x1C

    // CTRL register bits
    localparam int CTRL_SNAP_BIT = 0;
    localparam int CTRL_CLR_BIT  = 1;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // "STAT" in ASCII
    localparam logic [31:0] BLOCK_ID_DEFAULT = 32'h5354_4154;

    typedef enum logic [1:0] {
        W_IDLE,
        W_EXEC,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

endpackage

// File: rtl/stats_snapshot.sv
// Snapshot storage for the statistics counters.
// Holds one 64-bit packet count, one 64-bit byte count and a 32-bit count
// of how many snapshots have been taken (wraps naturally).
// Ports:
//   clk, rstn     clock, asynchronous active-low reset
//   load_i        one-cycle strobe: capture inputs and bump the count
//   pkt_i/byte_i  live counter values to capture
//   pkt_o/byte_o  captured counter values
//   cnt_o         number of snapshots since reset
module stats_snapshot (
    input  logic        clk,
    input  logic        rstn,
    input  logic        load_i,
    input  logic [63:0] pkt_i,
    input  logic [63:0] byte_i,
    output logic [63:0] pkt_o,
    output logic [63:0] byte_o,
    output logic [31:0] cnt_o
);

    logic [63:0] pkt_q;
    logic [63:0] byte_q;
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    assign cnt_d = cnt_q + 32'd1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pkt_q  <= 64'd0;
            byte_q <= 64'd0;
            cnt_q  <= 32'd0;
        end else if (load_i) begin
            pkt_q  <= pkt_i;
            byte_q <= byte_i;
            cnt_q  <= cnt_d;
        end
    end

    assign pkt_o  = pkt_q;
    assign byte_o = byte_q;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/stats_axil_reader.sv
// AXI4-Lite slave giving software access to the packet/byte statistics.
// Both 64-bit counters are captured together into snapshot registers on a
// CTRL.SNAP write so that LO/HI reads never tear; CTRL.CLR drives a
// one-cycle clear_counters pulse to the counter block.
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   s_axil_aw*/w*/b*   AXI4-Lite write address, data and response channels
//   s_axil_ar*/r*      AXI4-Lite read address and data channels
//   pkt_count_in       live 64-bit packet counter
//   byte_count_in      live 64-bit byte counter
//   clear_counters     one-cycle clear pulse to the counter block
module stats_axil_reader
    import stats_pkg::*;
#(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] BLOCK_ID   = BLOCK_ID_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [31:0]           s_axil_wdata,
    input  logic [3:0]            s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [31:0]           s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,
    input  logic [63:0]           pkt_count_in,
    input  logic [63:0]           byte_count_in,
    output logic                  clear_counters
);

    // Only address bits [4:2], wdata[1:0] and wstrb[0] carry meaning
    logic unused_bits;
    assign unused_bits = ^{s_axil_awaddr, s_axil_araddr, s_axil_wdata, s_axil_wstrb};

    logic [63:0] snap_pkt;
    logic [63:0] snap_byte;
    logic [31:0] snap_cnt;

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    wr_state_e   wr_state_q;
    logic        awready_q, wready_q;
    logic        aw_got_q, w_got_q;
    logic [2:0]  waddr_q, waddr_d;
    logic [1:0]  wbits_q, wbits_d;
    logic        wstrb0_q, wstrb0_d;
    logic        bvalid_q;
    logic [1:0]  bresp_q;
    logic        clr_q, snap_q;
    logic        aw_hs, w_hs, both_d, ctrl_hit_d, act_en_d;

    assign aw_hs = s_axil_awvalid && awready_q;
    assign w_hs  = s_axil_wvalid && wready_q;

    // Merge a handshake landing this cycle with anything captured earlier,
    // so AW and W may arrive in either order or together.
    always_comb begin
        waddr_d    = aw_hs ? s_axil_awaddr[4:2] : waddr_q;
        wbits_d    = w_hs ? s_axil_wdata[1:0] : wbits_q;
        wstrb0_d   = w_hs ? s_axil_wstrb[0] : wstrb0_q;
        both_d     = (aw_got_q || aw_hs) && (w_got_q || w_hs);
        ctrl_hit_d = (waddr_d == REG_CTRL);
        act_en_d   = ctrl_hit_d && wstrb0_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_state_q <= W_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            aw_got_q   <= 1'b0;
            w_got_q    <= 1'b0;
            waddr_q    <= 3'd0;
            wbits_q    <= 2'd0;
            wstrb0_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            clr_q      <= 1'b0;
            snap_q     <= 1'b0;
        end else begin
            // Action strobes are high only for the single W_EXEC cycle
            clr_q  <= 1'b0;
            snap_q <= 1'b0;
            case (wr_state_q)
                W_IDLE: begin
                    waddr_q  <= waddr_d;
                    wbits_q  <= wbits_d;
                    wstrb0_q <= wstrb0_d;
                    if (both_d) begin
                        awready_q  <= 1'b0;
                        wready_q   <= 1'b0;
                        aw_got_q   <= 1'b0;
                        w_got_q    <= 1'b0;
                        clr_q      <= act_en_d && wbits_d[CTRL_CLR_BIT];
                        snap_q     <= act_en_d && wbits_d[CTRL_SNAP_BIT];
                        bresp_q    <= ctrl_hit_d ? RESP_OKAY : RESP_SLVERR;
                        wr_state_q <= W_EXEC;
                    end else begin
                        aw_got_q  <= aw_got_q || aw_hs;
                        w_got_q   <= w_got_q || w_hs;
                        awready_q <= !(aw_got_q || aw_hs);
                        wready_q  <= !(w_got_q || w_hs);
                    end
                end
                W_EXEC: begin
                    bvalid_q   <= 1'b1;
                    wr_state_q <= W_RESP;
                end
                W_RESP: begin
                    if (s_axil_bready) begin
                        bvalid_q   <= 1'b0;
                        awready_q  <= 1'b1;
                        wready_q   <= 1'b1;
                        wr_state_q <= W_IDLE;
                    end
                end
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    assign s_axil_awready = awready_q;
    assign s_axil_wready  = wready_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;
    assign clear_counters = clr_q;

    // The snapshot loads at the edge closing W_EXEC, the same edge at which
    // the counter block clears, so SNAP+CLR captures the pre-clear values.
    stats_snapshot u_snapshot (
        .clk    (clk),
        .rstn   (rstn),
        .load_i (snap_q),
        .pkt_i  (pkt_count_in),
        .byte_i (byte_count_in),
        .pkt_o  (snap_pkt),
        .byte_o (snap_byte),
        .cnt_o  (snap_cnt)
    );

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    rd_state_e   rd_state_q;
    logic        arready_q;
    logic        rvalid_q;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        ar_hs;

    assign ar_hs = s_axil_arvalid && arready_q;

    always_comb begin
        rdata_d = 32'd0;
        rresp_d = RESP_OKAY;
        case (s_axil_araddr[4:2])
            REG_PKT_LO:   rdata_d = snap_pkt[31:0];
            REG_PKT_HI:   rdata_d = snap_pkt[63:32];
            REG_BYTE_LO:  rdata_d = snap_byte[31:0];
            REG_BYTE_HI:  rdata_d = snap_byte[63:32];
            REG_CTRL:     rdata_d = 32'd0;
            REG_SNAP_CNT: rdata_d = snap_cnt;
            REG_ID:       rdata_d = BLOCK_ID;
            default:      rresp_d = RESP_SLVERR;
        endcase
    end

    // rdata is frozen while in R_DATA, so a snapshot landing during a
    // stalled read cannot change what the master eventually sees.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= 32'd0;
            rresp_q    <= RESP_OKAY;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    arready_q <= !ar_hs;
                    if (ar_hs) begin
                        rdata_q    <= rdata_d;
                        rresp_q    <= rresp_d;
                        rvalid_q   <= 1'b1;
                        rd_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_axil_rready) begin
                        rvalid_q   <= 1'b0;
                        arready_q  <= 1'b1;
                        rd_state_q <= R_IDLE;
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    assign s_axil_arready = arready_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = rresp_q;

endmodule

// File: tb/tb_stats_axil_reader.sv
module tb_stats_axil_reader;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [31:0] ID_VAL = 32'h5354_4154;

    logic        clk;
    logic        rstn;
    logic [7:0]  s_axil_awaddr;
    logic        s_axil_awvalid;
    logic        s_axil_awready;
    logic [31:0] s_axil_wdata;
    logic [3:0]  s_axil_wstrb;
    logic        s_axil_wvalid;
    logic        s_axil_wready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_bvalid;
    logic        s_axil_bready;
    logic [7:0]  s_axil_araddr;
    logic        s_axil_arvalid;
    logic        s_axil_arready;
    logic [31:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;
    logic        s_axil_rvalid;
    logic        s_axil_rready;
    logic [63:0] pkt_count_in;
    logic [63:0] byte_count_in;
    logic        clear_counters;

    stats_axil_reader dut (
        .clk            (clk),
        .rstn           (rstn),
        .s_axil_awaddr  (s_axil_awaddr),
        .s_axil_awvalid (s_axil_awvalid),
        .s_axil_awready (s_axil_awready),
        .s_axil_wdata   (s_axil_wdata),
        .s_axil_wstrb   (s_axil_wstrb),
        .s_axil_wvalid  (s_axil_wvalid),
        .s_axil_wready  (s_axil_wready),
        .s_axil_bresp   (s_axil_bresp),
        .s_axil_bvalid  (s_axil_bvalid),
        .s_axil_bready  (s_axil_bready),
        .s_axil_araddr  (s_axil_araddr),
        .s_axil_arvalid (s_axil_arvalid),
        .s_axil_arready (s_axil_arready),
        .s_axil_rdata   (s_axil_rdata),
        .s_axil_rresp   (s_axil_rresp),
        .s_axil_rvalid  (s_axil_rvalid),
        .s_axil_rready  (s_axil_rready),
        .pkt_count_in   (pkt_count_in),
        .byte_count_in  (byte_count_in),
        .clear_counters (clear_counters)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Cycles during which the clear pulse was seen high
    int clr_cnt = 0;
    always @(posedge clk) if (clear_counters === 1'b1) clr_cnt <= clr_cnt + 1;

    // Scoreboards: expectations pushed when stimulus is driven
    logic [31:0] rq_data[$];
    logic [1:0]  rq_resp[$];
    logic [1:0]  bq[$];

    // Model of snapshot state and of the pending write's clear effect
    logic [63:0] m_pkt = 64'd0;
    logic [63:0] m_byte = 64'd0;
    logic [31:0] m_cnt = 32'd0;
    int exp_clr = 0;
    int clr_before = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic [1:0]  resp;
    } rvec_t;
    rvec_t tab[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [7:0] a, input logic [31:0] d, input logic [1:0] r);
        rvec_t v;
        v.addr = a; v.data = d; v.resp = r;
        tab.push_back(v);
    endtask

    task automatic read_issue(input logic [7:0] a, input logic [31:0] ed, input logic [1:0] er);
        int n;
        rq_data.push_back(ed);
        rq_resp.push_back(er);
        s_axil_araddr  = a;
        s_axil_arvalid = 1'b1;
        n = 0;
        while (!s_axil_arready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!s_axil_arready) begin
            s_axil_arvalid = 1'b0;
            chk("ar_timeout", 64'(s_axil_arready), 64'd1);
            return;
        end
        @(posedge clk); #1;
        s_axil_arvalid = 1'b0;
        chk("r_latency", 64'(s_axil_rvalid), 64'd1);
    endtask

    task automatic read_finish(input int hold);
        int n;
        logic [31:0] ed;
        logic [1:0]  er;
        n = 0;
        while (!s_axil_rvalid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        ed = rq_data.pop_front();
        er = rq_resp.pop_front();
        if (!s_axil_rvalid) begin
            chk("r_timeout", 64'(s_axil_rvalid), 64'd1);
            return;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
        end
        if (hold > 0) chk("r_hold", 64'(s_axil_rvalid), 64'd1);
        chk($sformatf("rdata@%0d", checks), 64'(s_axil_rdata), 64'(ed));
        chk("rresp", 64'(s_axil_rresp), 64'(er));
        s_axil_rready = 1'b1;
        @(posedge clk); #1;
        s_axil_rready = 1'b0;
        chk("r_done", 64'(s_axil_rvalid), 64'd0);
    endtask

    task automatic do_read(input logic [7:0] a, input logic [31:0] ed, input logic [1:0] er, input int hold);
        read_issue(a, ed, er);
        read_finish(hold);
    endtask

    task automatic write_issue(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                               input int aw_at, input int w_at);
        logic ok;
        bit aw_done, w_done, hs_aw, hs_w;
        int cyc;
        ok = (a[4:2] == 3'd4);
        bq.push_back(ok ? OKAY : SLVERR);
        exp_clr = (ok && s[0] && d[1]) ? 1 : 0;
        if (ok && s[0] && d[0]) begin
            m_pkt  = pkt_count_in;
            m_byte = byte_count_in;
            m_cnt  = m_cnt + 32'd1;
        end
        clr_before = clr_cnt;
        s_axil_awaddr = a;
        s_axil_wdata  = d;
        s_axil_wstrb  = s;
        aw_done = 0; w_done = 0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 100) begin
            s_axil_awvalid = !aw_done && (cyc >= aw_at);
            s_axil_wvalid  = !w_done && (cyc >= w_at);
            hs_aw = s_axil_awvalid && s_axil_awready;
            hs_w  = s_axil_wvalid && s_axil_wready;
            @(posedge clk); #1;
            if (hs_aw) aw_done = 1;
            if (hs_w)  w_done = 1;
            cyc++;
        end
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        chk("w_accept", 64'(aw_done && w_done), 64'd1);
    endtask

    task automatic write_finish(input int bhold);
        int n;
        int held;
        logic [1:0] er;
        n = 0;
        while (!s_axil_bvalid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        er = bq.pop_front();
        if (!s_axil_bvalid) begin
            chk("b_timeout", 64'(s_axil_bvalid), 64'd1);
            return;
        end
        held = 0;
        for (int i = 0; i < bhold; i++) begin
            @(posedge clk); #1;
            if (s_axil_bvalid) held++;
        end
        if (bhold > 0) chk("b_hold_cycles", 64'(held), 64'(bhold));
        chk("bresp", 64'(s_axil_bresp), 64'(er));
        s_axil_bready = 1'b1;
        @(posedge clk); #1;
        s_axil_bready = 1'b0;
        chk("b_done", 64'(s_axil_bvalid), 64'd0);
        chk("clr_pulses", 64'(clr_cnt - clr_before), 64'(exp_clr));
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_at, input int w_at, input int bhold);
        write_issue(a, d, s, aw_at, w_at);
        write_finish(bhold);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int n;
        rstn = 1'b0;
        s_axil_awaddr = 8'd0; s_axil_awvalid = 1'b0;
        s_axil_wdata = 32'd0; s_axil_wstrb = 4'd0; s_axil_wvalid = 1'b0;
        s_axil_bready = 1'b0;
        s_axil_araddr = 8'd0; s_axil_arvalid = 1'b0; s_axil_rready = 1'b0;
        pkt_count_in = 64'd0; byte_count_in = 64'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_awready", 64'(s_axil_awready), 64'd0);
        chk("rst_wready", 64'(s_axil_wready), 64'd0);
        chk("rst_arready", 64'(s_axil_arready), 64'd0);
        chk("rst_bvalid", 64'(s_axil_bvalid), 64'd0);
        chk("rst_rvalid", 64'(s_axil_rvalid), 64'd0);
        chk("rst_bresp", 64'(s_axil_bresp), 64'd0);
        chk("rst_rresp", 64'(s_axil_rresp), 64'd0);
        chk("rst_rdata", 64'(s_axil_rdata), 64'd0);
        chk("rst_clear", 64'(clear_counters), 64'd0);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
        chk("rel_arready", 64'(s_axil_arready), 64'd1);
        chk("rel_awready", 64'(s_axil_awready), 64'd1);

        // Register map after reset
        add_vec(8'h18, ID_VAL, OKAY);
        add_vec(8'h00, 32'd0, OKAY);
        add_vec(8'h04, 32'd0, OKAY);
        add_vec(8'h08, 32'd0, OKAY);
        add_vec(8'h0C, 32'd0, OKAY);
        add_vec(8'h14, 32'd0, OKAY);
        add_vec(8'h10, 32'd0, OKAY);
        add_vec(8'h1C, 32'd0, SLVERR);
        add_vec(8'h38, ID_VAL, OKAY);
        for (int i = 0; i < tab.size(); i++) do_read(tab[i].addr, tab[i].data, tab[i].resp, i % 3);
        tab.delete();

        // Snapshot, then move the live counters: reads must not follow
        pkt_count_in  = 64'h0000_0001_0000_0005;
        byte_count_in = 64'h0000_0000_0000_1F40;
        do_write(8'h10, 32'h1, 4'hF, 0, 0, 0);
        pkt_count_in  = 64'hFFFF_EEEE_DDDD_CCCC;
        byte_count_in = 64'h1234_5678_9ABC_DEF0;
        add_vec(8'h00, 32'h5, OKAY);
        add_vec(8'h04, 32'h1, OKAY);
        add_vec(8'h08, 32'h1F40, OKAY);
        add_vec(8'h0C, 32'h0, OKAY);
        add_vec(8'h14, 32'h1, OKAY);
        for (int i = 0; i < tab.size(); i++) do_read(tab[i].addr, tab[i].data, tab[i].resp, 0);
        tab.delete();

        // SNAP + CLR together
        pkt_count_in  = 64'd42;
        byte_count_in = 64'h0000_0002_0000_0010;
        do_write(8'h10, 32'h3, 4'hF, 0, 0, 0);
        add_vec(8'h00, 32'd42, OKAY);
        add_vec(8'h04, 32'd0, OKAY);
        add_vec(8'h0C, 32'h2, OKAY);
        add_vec(8'h14, 32'd2, OKAY);
        for (int i = 0; i < tab.size(); i++) do_read(tab[i].addr, tab[i].data, tab[i].resp, 1);
        tab.delete();

        // AW three cycles ahead of W, then W ahead of AW, B stalled 5 cycles
        do_write(8'h10, 32'h3, 4'hF, 0, 3, 5);
        do_read(8'h14, 32'd3, OKAY, 0);
        do_write(8'h10, 32'h3, 4'hF, 3, 0, 5);
        do_read(8'h14, 32'd4, OKAY, 0);

        // CTRL with wstrb[0]=0 does nothing but still answers OKAY
        do_write(8'h10, 32'h3, 4'hE, 0, 0, 0);
        do_read(8'h14, 32'd4, OKAY, 0);

        // Writes elsewhere: SLVERR, no side effect
        do_write(8'h00, 32'h3, 4'hF, 0, 0, 2);
        do_write(8'h1C, 32'h3, 4'hF, 1, 0, 0);
        do_read(8'h14, m_cnt, OKAY, 0);
        do_read(8'h1C, 32'd0, SLVERR, 2);

        // Snapshot while a read is stalled in its data phase
        read_issue(8'h00, m_pkt[31:0], OKAY);
        pkt_count_in = 64'h0000_0000_0000_0099;
        do_write(8'h10, 32'h1, 4'hF, 0, 0, 0);
        read_finish(0);
        do_read(8'h00, 32'h99, OKAY, 0);
        do_read(8'h14, m_cnt, OKAY, 0);

        // Reset with both responses outstanding and stalled
        write_issue(8'h10, 32'h1, 4'hF, 0, 0);
        n = 0;
        while (!s_axil_bvalid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("pre_rst_bvalid", 64'(s_axil_bvalid), 64'd1);
        read_issue(8'h14, m_cnt, OKAY);
        c0 = clr_cnt;
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_rvalid", 64'(s_axil_rvalid), 64'd0);
        chk("mid_rst_bvalid", 64'(s_axil_bvalid), 64'd0);
        void'(bq.pop_front());
        void'(rq_data.pop_front());
        void'(rq_resp.pop_front());
        m_pkt = 64'd0; m_byte = 64'd0; m_cnt = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_arready", 64'(s_axil_arready), 64'd1);
        do_read(8'h14, 32'd0, OKAY, 0);
        do_read(8'h00, 32'd0, OKAY, 0);
        do_read(8'h18, ID_VAL, OKAY, 0);
        chk("post_rst_no_clear", 64'(clr_cnt - c0), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
